xlate_decoder: RTL and testbench

//   Receive-side counterpart of the tag modulator: recovers tag data from codeword translation.

---
 rtl/xlate_decoder.sv | 118 +++++++++++
 tb/tb_xlate_decoder.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/xlate_decoder.sv
// Recovers tag bits from the XOR of paired ref/backscatter DBPSK symbols:
// majority vote per bit, LSB-first byte assembly, fixed-length frames.
module xlate_decoder #(
    parameter int SYMS_PER_BIT = 4,
    parameter int FRAME_BYTES  = 16,
    parameter int CNT_W        = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       sym_valid,
    input  logic       ref_bit,
    input  logic       bs_bit,
    output logic       tag_bit_valid,
    output logic       tag_bit,
    output logic       tie,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_done,
    output logic       busy
);
    localparam int BYTE_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  sym_cnt;
    logic [CNT_W-1:0]  ones;
    logic [2:0]        bit_cnt;
    logic [BYTE_W-1:0] byte_cnt;
    logic [7:0]        shreg;

    logic [CNT_W:0]    ones_total;
    logic [CNT_W+1:0]  twice;
    logic              vote, even, last_sym, last_bit, last_byte;

    // ones_total counts the symbol being accepted this cycle
    always_comb begin
        ones_total = {1'b0, ones} + (CNT_W+1)'(ref_bit ^ bs_bit);
        twice      = {ones_total, 1'b0};
        vote       = twice > (CNT_W+2)'(SYMS_PER_BIT);
        even       = twice == (CNT_W+2)'(SYMS_PER_BIT);
        last_sym   = sym_cnt == CNT_W'(SYMS_PER_BIT - 1);
        last_bit   = bit_cnt == 3'd7;
        last_byte  = byte_cnt == BYTE_W'(FRAME_BYTES - 1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            sym_cnt       <= '0;
            ones          <= '0;
            bit_cnt       <= '0;
            byte_cnt      <= '0;
            shreg         <= '0;
            tag_bit_valid <= 1'b0;
            tag_bit       <= 1'b0;
            tie           <= 1'b0;
            byte_valid    <= 1'b0;
            byte_data     <= '0;
            frame_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            tag_bit_valid <= 1'b0;
            tag_bit       <= 1'b0;
            tie           <= 1'b0;
            byte_valid    <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= COLLECT;
                        busy     <= 1'b1;
                        sym_cnt  <= '0;
                        ones     <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                COLLECT: begin
                    // a restart outranks any symbol arriving in the same cycle
                    if (start) begin
                        sym_cnt  <= '0;
                        ones     <= '0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end else if (sym_valid) begin
                        if (last_sym) begin
                            sym_cnt       <= '0;
                            ones          <= '0;
                            tag_bit_valid <= 1'b1;
                            tag_bit       <= vote;
                            tie           <= even;
                            shreg         <= {vote, shreg[7:1]};
                            bit_cnt       <= bit_cnt + 3'd1;
                            if (last_bit) begin
                                byte_valid <= 1'b1;
                                byte_data  <= {vote, shreg[7:1]};
                                if (last_byte) begin
                                    frame_done <= 1'b1;
                                    busy       <= 1'b0;
                                    state      <= IDLE;
                                    byte_cnt   <= '0;
                                end else begin
                                    byte_cnt <= byte_cnt + BYTE_W'(1);
                                end
                            end
                        end else begin
                            sym_cnt <= sym_cnt + CNT_W'(1);
                            ones    <= ones_total[CNT_W-1:0];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_xlate_decoder.sv
// Bench for xlate_decoder: three configurations share one stimulus stream and
// are checked each cycle against a frame-level model, plus directed literals.
module tb_xlate_decoder;
    logic clock = 1'b0;
    logic reset, start, sym_valid, ref_bit, bs_bit;
    logic [2:0] tbv, tbit, tie, bv, fd, busy;
    logic [7:0] bd [3];

    always #5 clock = ~clock;

    xlate_decoder #(.SYMS_PER_BIT(4), .FRAME_BYTES(1), .CNT_W(4)) dut0 (
        .clock(clock), .reset(reset), .start(start), .sym_valid(sym_valid),
        .ref_bit(ref_bit), .bs_bit(bs_bit), .tag_bit_valid(tbv[0]), .tag_bit(tbit[0]),
        .tie(tie[0]), .byte_valid(bv[0]), .byte_data(bd[0]), .frame_done(fd[0]), .busy(busy[0]));
    xlate_decoder #(.SYMS_PER_BIT(4), .FRAME_BYTES(2), .CNT_W(4)) dut1 (
        .clock(clock), .reset(reset), .start(start), .sym_valid(sym_valid),
        .ref_bit(ref_bit), .bs_bit(bs_bit), .tag_bit_valid(tbv[1]), .tag_bit(tbit[1]),
        .tie(tie[1]), .byte_valid(bv[1]), .byte_data(bd[1]), .frame_done(fd[1]), .busy(busy[1]));
    xlate_decoder #(.SYMS_PER_BIT(1), .FRAME_BYTES(1), .CNT_W(4)) dut2 (
        .clock(clock), .reset(reset), .start(start), .sym_valid(sym_valid),
        .ref_bit(ref_bit), .bs_bit(bs_bit), .tag_bit_valid(tbv[2]), .tag_bit(tbit[2]),
        .tie(tie[2]), .byte_valid(bv[2]), .byte_data(bd[2]), .frame_done(fd[2]), .busy(busy[2]));

    int nerr = 0, nchk = 0, cyc = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: frame-level view of each configuration
    int spb [3] = '{4, 4, 1};
    int fbn [3] = '{1, 2, 1};
    bit act [3];
    int gcnt [3], gsum [3], nbits [3];
    bit bits [3][8];
    bit e_tbv [3], e_bit [3], e_tie [3], e_bv [3], e_fd [3], e_busy [3];
    int e_bd [3];

    always @(posedge clock) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            e_tbv[i] = 0; e_bit[i] = 0; e_tie[i] = 0; e_bv[i] = 0; e_fd[i] = 0;
            if (reset !== 1'b1) begin
                act[i] = 0; e_busy[i] = 0; e_bd[i] = 0;
            end else if (start) begin
                act[i] = 1; e_busy[i] = 1; gcnt[i] = 0; gsum[i] = 0; nbits[i] = 0;
            end else if (act[i] && sym_valid) begin
                gcnt[i]++;
                gsum[i] += int'(ref_bit ^ bs_bit);
                if (gcnt[i] == spb[i]) begin
                    e_tbv[i] = 1;
                    e_bit[i] = (2 * gsum[i] > spb[i]);
                    e_tie[i] = (2 * gsum[i] == spb[i]);
                    bits[i][nbits[i] % 8] = e_bit[i];
                    nbits[i]++;
                    gcnt[i] = 0; gsum[i] = 0;
                    if (nbits[i] % 8 == 0) begin
                        e_bv[i] = 1;
                        e_bd[i] = 0;
                        for (int k = 0; k < 8; k++) e_bd[i] += int'(bits[i][k]) << k;
                        if (nbits[i] == 8 * fbn[i]) begin
                            e_fd[i] = 1; act[i] = 0; e_busy[i] = 0;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("tag_bit_valid[%0d]", i), int'(tbv[i]), int'(e_tbv[i]));
                check($sformatf("tag_bit[%0d]", i), int'(tbit[i]), int'(e_bit[i]));
                check($sformatf("tie[%0d]", i), int'(tie[i]), int'(e_tie[i]));
                check($sformatf("byte_valid[%0d]", i), int'(bv[i]), int'(e_bv[i]));
                check($sformatf("byte_data[%0d]", i), int'(bd[i]), e_bd[i]);
                check($sformatf("frame_done[%0d]", i), int'(fd[i]), int'(e_fd[i]));
                check($sformatf("busy[%0d]", i), int'(busy[i]), int'(e_busy[i]));
            end
        end
    end

    // Event capture for the directed literal checks
    logic [1:0] bitq0 [$];
    logic [7:0] byq0 [$], byq1 [$];
    bit fdq0 [$], fdq1 [$];
    int cycq1 [$];
    always @(negedge clock) begin
        if (chk_en) begin
            if (tbv[0] === 1'b1) bitq0.push_back({tie[0], tbit[0]});
            if (bv[0] === 1'b1) begin byq0.push_back(bd[0]); fdq0.push_back(fd[0]); end
            if (bv[1] === 1'b1) begin byq1.push_back(bd[1]); fdq1.push_back(fd[1]); cycq1.push_back(cyc); end
        end
    end

    task automatic clearq();
        bitq0.delete(); byq0.delete(); byq1.delete(); fdq0.delete(); fdq1.delete(); cycq1.delete();
    endtask
    task automatic tick();
        @(posedge clock); #1;
    endtask
    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask
    task automatic sym(input bit x);
        sym_valid = 1'b1; ref_bit = 1'($urandom); bs_bit = ref_bit ^ x;
        tick();
        sym_valid = 1'b0;
    endtask
    task automatic send_byte(input logic [7:0] b, input bit gaps);
        for (int k = 0; k < 8; k++)
            for (int s = 0; s < 4; s++) begin
                sym(b[k]);
                if (gaps && ($urandom_range(0, 2) == 0)) repeat ($urandom_range(1, 3)) tick();
            end
    endtask
    task automatic check_zero(input string name);
        check({name, " tbv"}, int'(tbv[0]), 0);
        check({name, " bv"}, int'(bv[0]), 0);
        check({name, " byte_data"}, int'(bd[0]), 0);
        check({name, " frame_done"}, int'(fd[0]), 0);
        check({name, " busy"}, int'(busy[0]), 0);
    endtask

    initial begin
        logic [7:0] acc;
        int d;
        reset = 1'b0; start = 1'b0; sym_valid = 1'b0; ref_bit = 1'b0; bs_bit = 1'b0;
        // 1: reset with random inputs
        tick();
        chk_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            start = 1'($urandom); sym_valid = 1'($urandom);
            ref_bit = 1'($urandom); bs_bit = 1'($urandom);
            tick();
        end
        start = 1'b0; sym_valid = 1'b0;
        check_zero("reset");
        reset = 1'b1;
        repeat (2) tick();

        // 2: single byte 0xA5 with random gaps
        clearq();
        pulse_start();
        send_byte(8'hA5, 1'b1);
        repeat (2) tick();
        check("A5 bit count", bitq0.size(), 8);
        acc = '0;
        foreach (bitq0[k]) if (k < 8) acc[k] = bitq0[k][0];
        check("A5 bits", int'(acc), 8'hA5);
        check("A5 byte count", byq0.size(), 1);
        if (byq0.size() == 1) begin
            check("A5 byte", int'(byq0[0]), 8'hA5);
            check("A5 frame_done", int'(fdq0[0]), 1);
        end
        check("A5 busy", int'(busy[0]), 0);

        // 3: majority and tie
        clearq();
        pulse_start();
        sym(1); sym(1); sym(1); sym(0);
        sym(1); sym(0); sym(0); sym(0);
        sym(1); sym(1); sym(0); sym(0);
        tick();
        check("vote count", bitq0.size(), 3);
        if (bitq0.size() == 3) begin
            check("vote 1110", int'(bitq0[0]), 2'b01);
            check("vote 1000", int'(bitq0[1]), 2'b00);
            check("vote 1100", int'(bitq0[2]), 2'b10);
        end

        // 4: back-to-back throughput on the two-byte frame
        clearq();
        pulse_start();
        d = cyc;
        send_byte(8'h3C, 1'b0);
        send_byte(8'hFF, 1'b0);
        repeat (2) tick();
        check("tp byte count", byq1.size(), 2);
        if (byq1.size() == 2) begin
            check("tp byte0", int'(byq1[0]), 8'h3C);
            check("tp byte1", int'(byq1[1]), 8'hFF);
            check("tp lat0", cycq1[0] - d, 32);
            check("tp lat1", cycq1[1] - d, 64);
            check("tp fd0", int'(fdq1[0]), 0);
            check("tp fd1", int'(fdq1[1]), 1);
        end

        // 5: restart mid-frame
        clearq();
        pulse_start();
        repeat (20) sym(1'($urandom));
        check("restart early bytes", byq0.size(), 0);
        pulse_start();
        send_byte(8'h5A, 1'b0);
        repeat (2) tick();
        check("restart byte count", byq0.size(), 1);
        if (byq0.size() == 1) check("restart byte", int'(byq0[0]), 8'h5A);

        // restart coinciding with the final deciding symbol
        clearq();
        pulse_start();
        for (int k = 0; k < 31; k++) sym(1'($urandom));
        start = 1'b1; sym(1'($urandom)); start = 1'b0;
        repeat (2) tick();
        check("restart-wins bytes", byq0.size(), 0);
        check("restart-wins busy", int'(busy[0]), 1);

        // 6: idle symbols, then reset mid-frame
        reset = 1'b0; tick(); reset = 1'b1; tick();
        clearq();
        for (int k = 0; k < 10; k++) begin
            sym_valid = 1'(k % 2); ref_bit = 1'($urandom); bs_bit = 1'($urandom); tick();
        end
        sym_valid = 1'b0;
        check("idle strobes", bitq0.size() + byq0.size(), 0);
        pulse_start();
        repeat (12) sym(1'($urandom));
        reset = 1'b0; tick(); reset = 1'b1;
        check_zero("midreset");
        tick();
        clearq();
        pulse_start();
        send_byte(8'h81, 1'b1);
        repeat (2) tick();
        check("fresh byte count", byq0.size(), 1);
        if (byq0.size() == 1) check("fresh byte", int'(byq0[0]), 8'h81);

        // randomized soak against the model
        for (int i = 0; i < 4000; i++) begin
            reset     = ($urandom_range(0, 599) != 0);
            start     = ($urandom_range(0, 199) == 0);
            sym_valid = ($urandom_range(0, 2) != 0);
            ref_bit   = 1'($urandom);
            bs_bit    = ($urandom_range(0, 3) == 0) ? ref_bit : ~ref_bit;
            if (i % 1000 > 700) bs_bit = 1'($urandom);
            tick();
        end
        reset = 1'b1; start = 1'b0; sym_valid = 1'b0;
        repeat (2) tick();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
